// File: rtl/hier_sink_ring.sv
// ============================================================================
//  Module   : hier_sink_ring
//  Purpose  : CTS sink array: LFSR-fed shift ring through top and child-group
//             flops, checked against a second LFSR with a saturating counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hier_sink_group #(
    parameter int SINKS_PER_GROUP = 8
) (
    input  logic childclk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out,
    input  logic en,
    input  logic clr
);
    logic [SINKS_PER_GROUP-1:0] q;

    always_ff @(posedge childclk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q[0] <= d_in;
            for (int i = 1; i < SINKS_PER_GROUP; i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign d_out = q[SINKS_PER_GROUP-1];
endmodule

module hier_sink_ring #(
    parameter int           TOP_SINKS       = 16,
    parameter int           NUM_GROUPS      = 4,
    parameter int           SINKS_PER_GROUP = 8,
    parameter logic [15:0]  LFSR_SEED       = 16'hACE1,
    parameter int           ERR_CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [15:0]              seed,
    input  logic                     en,
    input  logic                     inject_err,
    output logic                     chain_out,
    output logic                     checking,
    output logic                     err_flag,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    localparam int CHAIN_LEN = TOP_SINKS + NUM_GROUPS * SINKS_PER_GROUP;
    localparam int CNT_W     = $clog2(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, CHECK = 2'd2} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [15:0]        gen, chk, seed_eff;
    logic [TOP_SINKS-1:0] top_q;
    logic [NUM_GROUPS:0]  link;
    logic               shift, din, mismatch;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign seed_eff = (seed != 16'h0000) ? seed : LFSR_SEED;
    // load wins over en, so a load cycle never shifts
    assign shift    = en && !load && (state != IDLE);
    assign din      = gen[15] ^ inject_err;
    assign mismatch = shift && (state == CHECK) && (chain_out != chk[15]);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (load) begin
            state_nx = PRIME;
            cnt_nx   = '0;
        end else if (en && state == PRIME) begin
            if (cnt == CNT_W'(CHAIN_LEN - 1)) begin
                state_nx = CHECK;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gen       <= LFSR_SEED;
            chk       <= LFSR_SEED;
            checking  <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            checking <= (state_nx == CHECK);
            if (load) begin
                gen       <= seed_eff;
                chk       <= seed_eff;
                err_flag  <= 1'b0;
                err_count <= '0;
            end else begin
                if (shift) begin
                    gen <= lfsr_next(gen);
                end
                if (shift && state == CHECK) begin
                    chk <= lfsr_next(chk);
                end
                if (mismatch) begin
                    err_flag <= 1'b1;
                    if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
        end else if (load) begin
            top_q <= '0;
        end else if (shift) begin
            top_q[0] <= din;
            for (int i = 1; i < TOP_SINKS; i++) begin
                top_q[i] <= top_q[i-1];
            end
        end
    end

    assign link[0] = top_q[TOP_SINKS-1];

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
            hier_sink_group #(
                .SINKS_PER_GROUP(SINKS_PER_GROUP)
            ) u_group (
                .childclk (clk),
                .rst_n    (rst_n),
                .d_in     (link[g]),
                .d_out    (link[g+1]),
                .en       (shift),
                .clr      (load)
            );
        end
    endgenerate

    assign chain_out = link[NUM_GROUPS];
endmodule

`default_nettype wire

// File: tb/tb_hier_sink_ring.sv
// ============================================================================
//  Module   : tb_hier_sink_ring
//  Purpose  : Self-checking bench for hier_sink_ring (vector table + queue).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hier_sink_ring;
    localparam int          L    = 48;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        en = 1'b0;
    logic        inject_err = 1'b0;
    logic        chain_out, checking, err_flag;
    logic [7:0]  err_count;

    hier_sink_ring dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .seed       (seed),
        .en         (en),
        .inject_err (inject_err),
        .chain_out  (chain_out),
        .checking   (checking),
        .err_flag   (err_flag),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; logic inj; } cell_t;
    cell_t       q[$];
    logic [15:0] m_gen;
    int          m_st;     // 0 idle, 1 prime, 2 check
    int          m_cnt, m_errc;
    bit          m_errf;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [15:0] sd;
        int          pct;
        int          cycles;
        int          inj_at;
        int          exp_err;
        int          exp_flag;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < L; i++) q.push_back('{1'b0, 1'b0});
        m_cnt  = 0;
        m_errc = 0;
        m_errf = 0;
    endtask

    task automatic check_outputs();
        check("chain_out", int'(chain_out), int'(q[0].b));
        check("checking", int'(checking), (m_st == 2) ? 1 : 0);
        check("err_flag", int'(err_flag), int'(m_errf));
        check("err_count", int'(err_count), m_errc);
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic tick(input bit ld, input logic [15:0] sd, input bit e, input bit ij);
        cell_t c;
        load = ld; seed = sd; en = e; inject_err = ij;
        @(posedge clk);
        #1;
        if (ld) begin
            m_gen = (sd != 16'h0) ? sd : SEED;
            model_clear();
            m_st = 1;
        end else if (e && m_st != 0) begin
            // bits differ from the checker sequence exactly where they were injected
            if (m_st == 2 && q[0].inj) begin
                m_errf = 1;
                if (m_errc < 255) m_errc++;
            end
            q.push_back('{m_gen[15] ^ ij, ij});
            c = q.pop_front();
            m_gen = adv(m_gen);
            if (m_st == 1) begin
                if (m_cnt == L - 1) begin
                    m_st  = 2;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        check_outputs();
    endtask

    initial begin
        int edges, rise;
        bit e, ij;

        vecs[0] = '{16'h0000, 100, 1048, -1, 0, 0};
        vecs[1] = '{16'h1234,  70, 1200, -1, 0, 0};
        vecs[2] = '{16'hBEEF, 100,  200, 60, 1, 1};
        vecs[3] = '{16'h0001, 100,  150, 10, 1, 1};

        // reset state and IDLE immunity
        repeat (3) @(posedge clk);
        #1;
        m_st = 0; m_gen = SEED; model_clear();
        check_outputs();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 16'h0, 1, 1);

        for (int v = 0; v < 4; v++) begin
            tick(1, vecs[v].sd, 0, 0);
            edges = 0;
            rise  = -1;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                e  = ($urandom_range(99) < vecs[v].pct);
                ij = e ? (edges == vecs[v].inj_at) : 1'($urandom_range(1));
                tick(0, 16'h0, e, ij);
                if (e) edges++;
                if (checking && rise < 0) rise = edges;
            end
            check("vec_err_count", int'(err_count), vecs[v].exp_err);
            check("vec_err_flag", int'(err_flag), vecs[v].exp_flag);
            check("vec_rise_edges", rise, L);
        end

        // saturation then clear by load
        tick(1, 16'h5A5A, 0, 0);
        for (int i = 0; i < L; i++) tick(0, 16'h0, 1, 0);
        for (int i = 0; i < 300; i++) tick(0, 16'h0, 1, 1);
        for (int i = 0; i < 60; i++) tick(0, 16'h0, 1, 0);
        check("sat_count", int'(err_count), 255);
        check("sat_flag", int'(err_flag), 1);
        tick(1, 16'h0, 1, 1);
        check("sat_clear_count", int'(err_count), 0);
        check("sat_clear_flag", int'(err_flag), 0);

        // five errors, then asynchronous reset mid-CHECK
        for (int i = 0; i < L; i++) tick(0, 16'h0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 16'h0, 1, 1);
            tick(0, 16'h0, 1, 0);
            tick(0, 16'h0, 1, 0);
        end
        for (int i = 0; i < 60; i++) tick(0, 16'h0, 1, 0);
        check("pre_reset_count", int'(err_count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        m_st = 0; m_gen = SEED; model_clear();
        check_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // load together with en and inject: no shift, counter stays 0
        tick(1, 16'h0007, 1, 1);
        rise = -1;
        for (int i = 1; i <= L; i++) begin
            tick(0, 16'h0, 1, 0);
            if (checking && rise < 0) rise = i;
        end
        check("load_en_rise", rise, L);
        for (int i = 0; i < 100; i++) tick(0, 16'h0, 1, 0);
        check("post_load_errs", int'(err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
